// File: rtl/midi_event_sched.sv
// MIDI byte-stream parser feeding an event queue that is drained as Avalon-MM writes into the synth register map.
// Optional macro ALL_NOTES_OFF_EN: CC 123 queues a sweep entry that writes zero to all 128 key registers.
module midi_event_sched #(
    parameter int FIFO_DEPTH = 16,
    parameter int CHANNEL    = 0,
    parameter int OMNI       = 1,
    parameter int CC_BASE    = 20,
    parameter int CC_SHIFT   = 13
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        BYTE_VALID,
    input  logic [7:0]  BYTE_DATA,
    output logic        BYTE_READY,
    output logic        AVL_WRITE,
    output logic [7:0]  AVL_ADDR,
    output logic [31:0] AVL_WRITEDATA,
    input  logic        AVL_WAITREQUEST,
    output logic        BUSY,
    output logic        EVT_DROPPED
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef ALL_NOTES_OFF_EN
    localparam int EW = 29;
`else
    localparam int EW = 28;
`endif
    localparam logic [7:0]  CC_LO      = 8'(CC_BASE);
    localparam logic [7:0]  CC_HI      = 8'(CC_BASE + 6);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

`ifdef ALL_NOTES_OFF_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_SWEEP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE} state_t;
`endif

    function automatic logic [EW-1:0] key_entry(input logic [6:0] key, input logic [6:0] vel);
        logic [EW-1:0] e;
        e = '0;
        e[27:20] = {1'b0, key};
        e[19:0]  = (vel == 7'd0) ? 20'd0 : {12'd0, 1'b1, vel};
        return e;
    endfunction

    function automatic logic [EW-1:0] cc_entry(input logic [6:0] num, input logic [6:0] val);
        logic [EW-1:0] e;
        logic [7:0]    idx;
        idx = {1'b0, num} - CC_LO;
        e = '0;
        e[27:20] = {1'b1, 4'h0, idx[2:0]};
        e[19:0]  = {13'd0, val} << CC_SHIFT;
        return e;
    endfunction

    // Parser state: current channel status, and first data byte of a two-byte message
    logic          st_vld;
    logic [2:0]    st_kind;
    logic [3:0]    st_chan;
    logic          have_first;
    logic [6:0]    byte1;
    logic          accept, is_rt, is_sys, one_byte, chan_ok, msg_done;
    logic          evt_push, evt_drop;
    logic [EW-1:0] evt_entry;

    assign accept   = BYTE_VALID && BYTE_READY;
    assign is_rt    = (BYTE_DATA[7:3] == 5'b11111);
    assign is_sys   = (BYTE_DATA[7:4] == 4'hF) && !is_rt;
    assign one_byte = (st_kind == 3'd4) || (st_kind == 3'd5);
    assign chan_ok  = (OMNI != 0) || (st_chan == 4'(CHANNEL));
    assign msg_done = accept && !BYTE_DATA[7] && st_vld && (one_byte || have_first);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            st_vld     <= 1'b0;
            st_kind    <= 3'd0;
            st_chan    <= 4'd0;
            have_first <= 1'b0;
        end else if (accept && !is_rt) begin
            if (is_sys) begin
                st_vld     <= 1'b0;
                have_first <= 1'b0;
            end else if (BYTE_DATA[7]) begin
                st_vld     <= 1'b1;
                st_kind    <= BYTE_DATA[6:4];
                st_chan    <= BYTE_DATA[3:0];
                have_first <= 1'b0;
            end else if (st_vld && !one_byte) begin
                have_first <= !have_first;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (accept && !BYTE_DATA[7] && st_vld && !one_byte && !have_first)
            byte1 <= BYTE_DATA[6:0];
    end

    always_comb begin
        evt_push  = 1'b0;
        evt_drop  = 1'b0;
        evt_entry = '0;
        if (msg_done && !one_byte) begin
            case (st_kind)
                3'd0: begin
                    evt_push  = 1'b1;
                    evt_entry = key_entry(byte1, 7'd0);
                end
                3'd1: begin
                    evt_push  = 1'b1;
                    evt_entry = key_entry(byte1, BYTE_DATA[6:0]);
                end
                3'd3: begin
                    if ({1'b0, byte1} >= CC_LO && {1'b0, byte1} <= CC_HI) begin
                        evt_push  = 1'b1;
                        evt_entry = cc_entry(byte1, BYTE_DATA[6:0]);
                    end else begin
                        evt_drop = 1'b1;
                    end
`ifdef ALL_NOTES_OFF_EN
                    if (byte1 == 7'd123) begin
                        evt_push  = 1'b1;
                        evt_drop  = 1'b0;
                        evt_entry = {1'b1, 28'd0};
                    end
`endif
                end
                default: ;
            endcase
            // Aftertouch / pitch bend never reach here as events, so only real events get filtered
            if (!chan_ok && (st_kind == 3'd0 || st_kind == 3'd1 || st_kind == 3'd3)) begin
                evt_push = 1'b0;
                evt_drop = 1'b1;
            end
        end
    end

    // ---- stage p0: decoded event, pushed into the queue one cycle after the final byte
    logic          evt_vld_p0;
    logic          evt_drop_p0;
    logic [EW-1:0] evt_entry_p0;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            evt_vld_p0  <= 1'b0;
            evt_drop_p0 <= 1'b0;
        end else begin
            evt_vld_p0  <= evt_push;
            evt_drop_p0 <= evt_drop;
        end
    end

    always_ff @(posedge CLK) begin
        if (evt_push)
            evt_entry_p0 <= evt_entry;
    end

    assign EVT_DROPPED = evt_drop_p0;

    // ---- event queue
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;
    logic [EW-1:0] head;
    logic          push, pop, fifo_avail;
    state_t        state, state_next;

    assign push       = evt_vld_p0 && (count != FULL_COUNT);
    assign pop        = (state == S_LOAD) && (count != '0);
    assign count_next = count + (AW + 1)'(push) - (AW + 1)'(pop);
    assign head       = fifo_mem[rd_ptr];
    assign fifo_avail = (count != '0) || push;

    always_ff @(posedge CLK) begin
        if (push)
            fifo_mem[wr_ptr] <= evt_entry_p0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            BYTE_READY <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count      <= count_next;
            BYTE_READY <= (count_next != FULL_COUNT);
        end
    end

    // ---- writer FSM
    logic [19:0] wdata;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        AVL_WRITE  = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_avail)
                    state_next = S_LOAD;
            end
            S_LOAD: begin
                if (count == '0)
                    state_next = S_IDLE;
`ifdef ALL_NOTES_OFF_EN
                else if (head[28])
                    state_next = S_SWEEP;
`endif
                else
                    state_next = S_WRITE;
            end
            S_WRITE: begin
                AVL_WRITE = 1'b1;
                if (!AVL_WAITREQUEST)
                    state_next = fifo_avail ? S_LOAD : S_IDLE;
            end
`ifdef ALL_NOTES_OFF_EN
            S_SWEEP: begin
                AVL_WRITE = 1'b1;
                if (!AVL_WAITREQUEST && AVL_ADDR == 8'd127)
                    state_next = S_IDLE;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // A sweep entry carries addr 0 / data 0, so loading it primes the first key write
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            AVL_ADDR <= 8'd0;
            wdata    <= 20'd0;
        end else if (pop) begin
            AVL_ADDR <= head[27:20];
            wdata    <= head[19:0];
        end
`ifdef ALL_NOTES_OFF_EN
        else if (state == S_SWEEP && !AVL_WAITREQUEST && AVL_ADDR != 8'd127) begin
            AVL_ADDR <= AVL_ADDR + 8'd1;
        end
`endif
    end

    assign AVL_WRITEDATA = {12'd0, wdata};
    assign BUSY          = (count != '0) || (state != S_IDLE);

endmodule

// File: tb/tb_midi_event_sched.sv
// Randomized and directed bench for midi_event_sched with a byte-level reference model and write scoreboard.
module tb_midi_event_sched;
    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic        BYTE_VALID = 1'b0;
    logic [7:0]  BYTE_DATA = 8'd0;
    logic        BYTE_READY;
    logic        AVL_WRITE;
    logic [7:0]  AVL_ADDR;
    logic [31:0] AVL_WRITEDATA;
    logic        BUSY;
    logic        EVT_DROPPED;
    logic        wr_hold = 1'b0;
    logic        rnd_mode = 1'b0;
    logic        rnd_bit = 1'b0;
    logic        wreq;

    assign wreq = rnd_mode ? rnd_bit : wr_hold;

    midi_event_sched dut (
        .CLK(CLK), .RESET_N(RESET_N), .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA),
        .BYTE_READY(BYTE_READY), .AVL_WRITE(AVL_WRITE), .AVL_ADDR(AVL_ADDR),
        .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_WAITREQUEST(wreq), .BUSY(BUSY),
        .EVT_DROPPED(EVT_DROPPED)
    );

    always #5 CLK = ~CLK;

`ifdef ALL_NOTES_OFF_EN
    localparam bit ANOE = 1'b1;
`else
    localparam bit ANOE = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int drops_exp = 0;
    int drops_seen = 0;
    logic [39:0] exp_q[$];
    logic [39:0] seen_q[$];
    int  m_status = -1;
    bit  m_have = 1'b0;
    int  m_b1 = 0;
    bit  prev_stall = 1'b0;
    logic [7:0]  prev_addr = 8'd0;
    logic [31:0] prev_data = 32'd0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic exp_push(input int a, input int d);
        exp_q.push_back({8'(a), 32'(d)});
    endtask

    task automatic model_reset();
        m_status = -1;
        m_have   = 1'b0;
        exp_q.delete();
    endtask

    // Reference behaviour of one accepted byte, straight from the message rules
    task automatic model_byte(input int b);
        int hi;
        if (b >= 'hF8) return;
        if (b >= 'hF0) begin m_status = -1; m_have = 1'b0; return; end
        if (b >= 'h80) begin m_status = b; m_have = 1'b0; return; end
        if (m_status < 0) return;
        hi = m_status / 16;
        if (hi == 12 || hi == 13) return;
        if (!m_have) begin m_b1 = b; m_have = 1'b1; return; end
        m_have = 1'b0;
        case (hi)
            8:  exp_push(m_b1, 0);
            9:  exp_push(m_b1, (b == 0) ? 0 : 128 + b);
            11: begin
                if (ANOE && m_b1 == 123)
                    for (int k = 0; k < 128; k++) exp_push(k, 0);
                else if (m_b1 >= 20 && m_b1 <= 26)
                    exp_push(128 + m_b1 - 20, (b * 8192) % (1 << 20));
                else
                    drops_exp++;
            end
            default: ;
        endcase
    endtask

    always @(negedge CLK) begin
        if (!RESET_N) begin
            prev_stall = 1'b0;
        end else begin
            if (EVT_DROPPED) drops_seen++;
            if (AVL_WRITE) begin
                if (prev_stall) begin
                    chk("hold_addr", 32'(AVL_ADDR), 32'(prev_addr));
                    chk("hold_data", AVL_WRITEDATA, prev_data);
                end
                if (!wreq) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: addr %h data %h, no write expected", AVL_ADDR, AVL_WRITEDATA);
                    end else begin
                        logic [39:0] e;
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(AVL_ADDR), 32'(e[39:32]));
                        chk("wr_data", AVL_WRITEDATA, e[31:0]);
                    end
                    seen_q.push_back({AVL_ADDR, AVL_WRITEDATA});
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_addr  = AVL_ADDR;
                    prev_data  = AVL_WRITEDATA;
                end
            end else begin
                if (prev_stall) chk("write_abandoned", 32'(AVL_WRITE), 32'd1);
                prev_stall = 1'b0;
            end
        end
    end

    task automatic send(input int b);
        int n;
        n = 0;
        BYTE_VALID = 1'b1;
        BYTE_DATA  = 8'(b);
        @(negedge CLK);
        while (!BYTE_READY) begin
            n++;
            if (n > 5000) begin
                chk("byte_ready_timeout", 32'(BYTE_READY), 32'd1);
                BYTE_VALID = 1'b0;
                return;
            end
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;
        acc_cyc = cyc;
        model_byte(b);
        BYTE_VALID = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        @(negedge CLK);
        while ((exp_q.size() != 0 || BUSY) && n < bound) begin
            @(negedge CLK);
            n++;
        end
        repeat (4) @(negedge CLK);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("busy_idle", 32'(BUSY), 32'd0);
        chk("drop_count", 32'(drops_seen), 32'(drops_exp));
    endtask

    function automatic int rand_byte();
        int r;
        int ch;
        r  = int'($urandom_range(0, 99));
        ch = int'($urandom_range(0, 15));
        if (r < 12) return 'h90 | ch;
        if (r < 18) return 'h80 | ch;
        if (r < 27) return 'hB0 | ch;
        if (r < 31) begin
            case ($urandom_range(0, 3))
                0: return 'hA0 | ch;
                1: return 'hC0 | ch;
                2: return 'hD0 | ch;
                default: return 'hE0 | ch;
            endcase
        end
        if (r < 33) return int'($urandom_range('hF0, 'hF7));
        if (r < 36) return int'($urandom_range('hF8, 'hFF));
        r = int'($urandom_range(0, 9));
        if (r < 3) return int'($urandom_range(18, 28));
        if (r == 3) return 123;
        if (r == 4) return 0;
        return int'($urandom_range(0, 127));
    endfunction

    initial begin
        int n;
        int seen_cyc;
        int d0;
        #2 RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_byte_ready", 32'(BYTE_READY), 32'd0);
        chk("rst_avl_write", 32'(AVL_WRITE), 32'd0);
        chk("rst_avl_addr", 32'(AVL_ADDR), 32'd0);
        chk("rst_avl_data", AVL_WRITEDATA, 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_dropped", 32'(EVT_DROPPED), 32'd0);
        @(posedge CLK); #1 RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        chk("ready_after_reset", 32'(BYTE_READY), 32'd1);

        // Single note-on: latency and literal values
        @(posedge CLK); #1;
        seen_q.delete();
        send('h90); send('h3C); send('h64);
        seen_cyc = -100;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (AVL_WRITE) begin seen_cyc = cyc; break; end
        end
        chk("latency_cycles", 32'(seen_cyc - acc_cyc + 1), 32'd3);
        @(negedge CLK);
        chk("write_one_cycle", 32'(AVL_WRITE), 32'd0);
        wait_drain(50);
        chk("note_on_count", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() >= 1) begin
            chk("note_on_addr", 32'(seen_q[0][39:32]), 32'h3C);
            chk("note_on_data", seen_q[0][31:0], 32'hE4);
        end

        // Running status with velocity-zero note-on
        seen_q.delete();
        send('h90); send('h40); send('h7F); send('h40); send('h00);
        wait_drain(50);
        chk("rs_count", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() >= 2) begin
            chk("rs_addr0", 32'(seen_q[0][39:32]), 32'h40);
            chk("rs_data0", seen_q[0][31:0], 32'hFF);
            chk("rs_addr1", 32'(seen_q[1][39:32]), 32'h40);
            chk("rs_data1", seen_q[1][31:0], 32'h00);
        end

        // Mapped control change
        seen_q.delete();
        send('hB0); send(21); send('h05);
        wait_drain(50);
        chk("cc_count", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() >= 1) begin
            chk("cc_addr", 32'(seen_q[0][39:32]), 32'h81);
            chk("cc_data", seen_q[0][31:0], 32'h0000A000);
        end

        // Realtime byte in the middle of a message
        seen_q.delete();
        send('h90); send('h3C); send('hF8); send('h64);
        wait_drain(50);
        chk("rt_count", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() >= 1) begin
            chk("rt_addr", 32'(seen_q[0][39:32]), 32'h3C);
            chk("rt_data", seen_q[0][31:0], 32'hE4);
        end

        // Backpressure: 17 note-ons against a stalled slave
        seen_q.delete();
        wr_hold = 1'b1;
        send('h90);
        for (int i = 0; i < 17; i++) begin
            send('h20 + i);
            send('h40 + i);
        end
        repeat (3) @(negedge CLK);
        chk("ready_when_full", 32'(BYTE_READY), 32'd0);
        chk("busy_when_full", 32'(BUSY), 32'd1);
        repeat (20) @(negedge CLK);
        @(posedge CLK); #1 wr_hold = 1'b0;
        wait_drain(200);
        chk("full_count", 32'(seen_q.size()), 32'd17);
        if (seen_q.size() >= 17) begin
            chk("full_last_addr", 32'(seen_q[16][39:32]), 32'h30);
            chk("full_last_data", seen_q[16][31:0], 32'hD0);
        end
        chk("ready_after_drain", 32'(BYTE_READY), 32'd1);

        // CC 123
        seen_q.delete();
        d0 = drops_seen;
        send('hB0); send(123); send(0);
        wait_drain(1000);
`ifdef ALL_NOTES_OFF_EN
        chk("sweep_count", 32'(seen_q.size()), 32'd128);
        if (seen_q.size() >= 128) begin
            chk("sweep_first_addr", 32'(seen_q[0][39:32]), 32'h00);
            chk("sweep_last_addr", 32'(seen_q[127][39:32]), 32'h7F);
            chk("sweep_last_data", seen_q[127][31:0], 32'h0);
        end
        chk("sweep_no_drop", 32'(drops_seen - d0), 32'd0);
`else
        chk("cc123_no_write", 32'(seen_q.size()), 32'd0);
        chk("cc123_dropped", 32'(drops_seen - d0), 32'd1);
`endif

        // Randomized traffic with random slave stalls
        @(posedge CLK); #1 rnd_mode = 1'b1;
        for (int i = 0; i < 600; i++) send(rand_byte());
        @(posedge CLK); #1 rnd_mode = 1'b0;
        wait_drain(20000);

        // Reset in the middle of a stalled write
        send('hF0);
        seen_q.delete();
        wr_hold = 1'b1;
        send('h90); send('h10); send('h20); send('h11); send('h21); send('h12); send('h22);
        n = 0;
        while (!AVL_WRITE && n < 50) begin @(negedge CLK); n++; end
        chk("reset_write_seen", 32'(AVL_WRITE), 32'd1);
        @(posedge CLK); #3;
        RESET_N = 1'b0;
        #1;
        chk("reset_kills_write", 32'(AVL_WRITE), 32'd0);
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_ready", 32'(BYTE_READY), 32'd0);
        model_reset();
        wr_hold = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        repeat (10) @(negedge CLK);
        chk("post_reset_busy", 32'(BUSY), 32'd0);
        chk("post_reset_no_write", 32'(seen_q.size()), 32'd0);
        send('h90); send('h3C); send('h64);
        wait_drain(50);
        chk("post_reset_note", 32'(seen_q.size()), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
